// File: rtl/chicken_referee_pkg.sv
// Shared definitions for the chicken_referee turn/tail referee:
// FSM state encoding, board/tail/player limits and small arithmetic helpers.
package chicken_referee_pkg;

  // Board, tail and player limits.
  localparam logic [4:0] MAX_POS     = 5'd23;
  localparam logic [1:0] TAIL_MAX    = 2'd3;
  localparam int         MAX_PLAYERS = 4;

  // Referee FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STEP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WIN    = 3'd4
  } state_e;

  typedef logic [4:0] pos_t;
  typedef logic [1:0] tail_t;

  // Map the raw player-count input onto the supported range; anything
  // outside 2..4 plays as a two-player game.
  function automatic logic [2:0] eff_players(input logic [4:0] n);
    logic [2:0] res;
    if ((n >= 5'd2) && (n <= 5'd4)) begin
      res = n[2:0];
    end else begin
      res = 3'd2;
    end
    return res;
  endfunction

  // Next player index, wrapping at the active player count. A turn value
  // at or beyond the count also wraps to 0 so turn can never reach an
  // inactive seat.
  function automatic logic [1:0] next_turn(input logic [1:0] t, input logic [2:0] n);
    logic [2:0] nx;
    logic [1:0] res;
    nx = {1'b0, t} + 3'd1;
    if (nx >= n) begin
      res = 2'd0;
    end else begin
      res = nx[1:0];
    end
    return res;
  endfunction

  // Tail count after a capture: own tails + captured tails + the captured
  // player's own tail, saturated at TAIL_MAX.
  function automatic tail_t sat_tail_sum(input tail_t a, input tail_t b);
    logic [2:0] s;
    tail_t      res;
    s = {1'b0, a} + {1'b0, b} + 3'd1;
    if (s > {1'b0, TAIL_MAX}) begin
      res = TAIL_MAX;
    end else begin
      res = s[1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/chicken_referee_if.sv
// Game-side bundle of the referee: configuration, button/card inputs,
// position feedback from the per-player counters and the referee outputs.
// The referee sits on the slave side; the game environment is the master.
interface chicken_referee_if;

  logic [4:0] N;
  logic       btn;
  logic       card_match;
  logic [4:0] p1_cnt;
  logic [4:0] p2_cnt;
  logic [4:0] p3_cnt;
  logic [4:0] p4_cnt;
  logic [3:0] p_da;
  logic [1:0] turn;
  logic [1:0] p1_tail;
  logic [1:0] p2_tail;
  logic [1:0] p3_tail;
  logic [1:0] p4_tail;
  logic [2:0] winner;
  logic       busy;

  modport slave (
    input  N, btn, card_match, p1_cnt, p2_cnt, p3_cnt, p4_cnt,
    output p_da, turn, p1_tail, p2_tail, p3_tail, p4_tail, winner, busy
  );

  modport master (
    output N, btn, card_match, p1_cnt, p2_cnt, p3_cnt, p4_cnt,
    input  p_da, turn, p1_tail, p2_tail, p3_tail, p4_tail, winner, busy
  );

endinterface

// File: rtl/chicken_referee_capture_detect.sv
// capture_detect: purely combinational search for another active player
// standing on the same square as the current player. Positions are
// compared as raw 5-bit values; the lowest matching index wins.
module capture_detect
  import chicken_referee_pkg::*;
(
  input  logic [MAX_PLAYERS-1:0][4:0] pos_i,
  input  logic [1:0]                  turn_i,
  input  logic [2:0]                  n_eff_i,
  output logic                        hit_o,
  output logic [1:0]                  idx_o
);

  logic [MAX_PLAYERS-1:0] match_s;
  pos_t                   cur_pos_s;

  // Flag every active, non-current player sharing the current square.
  always_comb begin
    cur_pos_s = pos_i[turn_i];
    match_s   = '0;
    for (int j = 0; j < MAX_PLAYERS; j++) begin
      match_s[j] = (j[2:0] < n_eff_i) && (j[1:0] != turn_i) && (pos_i[j] == cur_pos_s);
    end
  end

  // Priority-encode the match vector, lowest index first.
  always_comb begin
    hit_o = |match_s;
    casez (match_s)
      4'b???1: idx_o = 2'd0;
      4'b??10: idx_o = 2'd1;
      4'b?100: idx_o = 2'd2;
      4'b1000: idx_o = 2'd3;
      default: idx_o = 2'd0;
    endcase
  end

endmodule

// File: rtl/chicken_referee.sv
// chicken_referee: turn sequencing, step enable, capture and win detection
// for a 2..4 player chicken-race board game. A matching card steps the
// current player one square (STEP), waits for the position counter to
// settle (SETTLE), then resolves captures and the win condition (CHECK).
// All outputs are registered; reset is asynchronous and active-low.
module chicken_referee
  import chicken_referee_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  chicken_referee_if.slave bus
);

  state_e                          state_q;
  state_e                          state_d;
  logic [1:0]                      turn_q;
  logic [1:0]                      turn_d;
  logic [MAX_PLAYERS-1:0][1:0]     tail_q;
  logic [MAX_PLAYERS-1:0][1:0]     tail_d;
  logic [2:0]                      winner_q;
  logic [2:0]                      winner_d;
  logic [3:0]                      p_da_q;
  logic [3:0]                      p_da_d;
  logic                            busy_q;
  logic                            busy_d;

  logic [2:0]                      n_eff_s;
  logic [MAX_PLAYERS-1:0][4:0]     pos_s;
  logic                            hit_s;
  logic [1:0]                      hit_idx_s;
  tail_t                           cur_tail_s;
  tail_t                           new_tail_s;

  assign n_eff_s = eff_players(bus.N);
  assign pos_s   = {bus.p4_cnt, bus.p3_cnt, bus.p2_cnt, bus.p1_cnt};

  capture_detect u_capture_detect (
    .pos_i   (pos_s),
    .turn_i  (turn_q),
    .n_eff_i (n_eff_s),
    .hit_o   (hit_s),
    .idx_o   (hit_idx_s)
  );

  // Next-state, turn, tail-bank and output decode for the referee FSM.
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    tail_d     = tail_q;
    winner_d   = winner_q;
    p_da_d     = 4'b0000;
    cur_tail_s = tail_q[turn_q];
    new_tail_s = cur_tail_s;

    case (state_q)
      ST_IDLE: begin
        if (bus.btn) begin
          if (bus.card_match) begin
            // Enable lands in the same cycle the FSM sits in STEP.
            state_d = ST_STEP;
            p_da_d  = 4'b0001 << turn_q;
          end else begin
            turn_d = next_turn(turn_q, n_eff_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_STEP: begin
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (hit_s) begin
          new_tail_s        = sat_tail_sum(cur_tail_s, tail_q[hit_idx_s]);
          tail_d[turn_q]    = new_tail_s;
          tail_d[hit_idx_s] = 2'd0;
        end else begin
          new_tail_s = cur_tail_s;
        end
        // Holding N-1 tails means every opponent's tail has been taken.
        if ({1'b0, new_tail_s} >= (n_eff_s - 3'd1)) begin
          state_d  = ST_WIN;
          winner_d = {1'b0, turn_q} + 3'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WIN: begin
        state_d = ST_WIN;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, turn, tail bank, winner and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      turn_q   <= 2'd0;
      tail_q   <= '0;
      winner_q <= 3'd0;
      p_da_q   <= 4'b0000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      tail_q   <= tail_d;
      winner_q <= winner_d;
      p_da_q   <= p_da_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.p_da    = p_da_q;
  assign bus.turn    = turn_q;
  assign bus.p1_tail = tail_q[0];
  assign bus.p2_tail = tail_q[1];
  assign bus.p3_tail = tail_q[2];
  assign bus.p4_tail = tail_q[3];
  assign bus.winner  = winner_q;
  assign bus.busy    = busy_q;

endmodule
